bcd_seq_conv: RTL and testbench

Parametrised, sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock. It replaces the fixed 8-bit, two-digit lookup converter in the score/timer display path. It adds a start/done handshake, a configurable input width and digit count, overflow flagging, and a leading-zero blank mask for the seven-segment driver.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bcd_seq_conv.sv | 138 +++++++++++++
 tb/tb_bcd_seq_conv.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock,
// with start/done handshake, overflow forcing and leading-zero blank mask.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      binary_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o,
    output logic [DIGITS-1:0]     lz_mask_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = clog2(BIN_W + 1);
    localparam int CMP_W = (BIN_W > 21) ? BIN_W : 21;
    localparam logic [CMP_W-1:0] OVF_LIMIT = CMP_W'(pow10(DIGITS));

    state_t                 state_q, state_d;
    logic [BIN_W-1:0]       sh_q, sh_d;
    logic [BCD_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovfo_q, ovfo_d;
    logic [DIGITS-1:0]      lz_q, lz_d;
    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Digit i is a leading zero when it and every digit above it are zero.
    function automatic logic [DIGITS-1:0] lz_of(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              run;
        m   = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run  = run & (d[4*i +: 4] == 4'd0);
            m[i] = run;
        end
        return m;
    endfunction

    function automatic logic [BCD_W-1:0] blank_fill();
        return {DIGITS{BCD_BLANK}};
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (acc_adj[4*g +: 4])
        );
    end

    assign shifted = {acc_adj, sh_q} << 1;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovfo_d  = ovfo_q;
        lz_d    = lz_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sh_d    = binary_i;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = (CMP_W'(binary_i) >= OVF_LIMIT);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shifted[BIN_W +: BCD_W];
                sh_d  = shifted[BIN_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (ovf_q) begin
                    bcd_d  = blank_fill();
                    ovfo_d = 1'b1;
                    lz_d   = '0;
                end else begin
                    bcd_d  = acc_q;
                    ovfo_d = 1'b0;
                    lz_d   = lz_of(acc_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovfo_q  <= 1'b0;
            lz_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovfo_q  <= ovfo_d;
            lz_q    <= lz_d;
        end
    end

    // Working registers carry no reset; they are always reloaded on start.
    always_ff @(posedge clk_i) begin
        sh_q  <= sh_d;
        acc_q <= acc_d;
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = ovfo_q;
    assign lz_mask_o  = lz_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed bench for bcd_seq_conv in three configurations: (8,3), (8,2) and (16,5).
module tb_bcd_seq_conv;

    logic        clk, rst;
    logic        start_a, start_b, start_c;
    logic [15:0] bin16;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic [2:0]  lz_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  lz_b;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;
    logic [4:0]  lz_c;

    int vecs = 0;
    int miss = 0;

    bcd_seq_conv #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .binary_i(bin16[7:0]),
        .busy_o(busy_a), .done_o(done_a), .bcd_o(bcd_a), .overflow_o(ovf_a), .lz_mask_o(lz_a));

    bcd_seq_conv #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .binary_i(bin16[7:0]),
        .busy_o(busy_b), .done_o(done_b), .bcd_o(bcd_b), .overflow_o(ovf_b), .lz_mask_o(lz_b));

    bcd_seq_conv #(.BIN_W(16), .DIGITS(5)) dut_c (
        .clk_i(clk), .rst_i(rst), .start_i(start_c), .binary_i(bin16),
        .busy_o(busy_c), .done_o(done_c), .bcd_o(bcd_c), .overflow_o(ovf_c), .lz_mask_o(lz_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [15:0] bin;
        logic [23:0] bcd;
        logic [5:0]  lz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic rd(input int sel, output logic bz, output logic dn,
                      output logic [23:0] b, output logic [5:0] l, output logic o);
        bz = 1'b0; dn = 1'b0; b = '0; l = '0; o = 1'b0;
        case (sel)
            0: begin bz = busy_a; dn = done_a; b = {12'd0, bcd_a}; l = {3'd0, lz_a}; o = ovf_a; end
            1: begin bz = busy_b; dn = done_b; b = {16'd0, bcd_b}; l = {4'd0, lz_b}; o = ovf_b; end
            default: begin bz = busy_c; dn = done_c; b = {4'd0, bcd_c}; l = {1'b0, lz_c}; o = ovf_c; end
        endcase
    endtask

    // Called 1 time unit after a rising edge; returns cycles from accepting edge to done.
    task automatic convert(input int sel, input logic [15:0] v, output int lat,
                           output logic [23:0] b, output logic [5:0] l, output logic o);
        logic bz, dn;
        bin16 = v;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        lat = -1;
        b = '0; l = '0; o = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk); #1;
            rd(sel, bz, dn, b, l, o);
            if (dn) lat = n;
        end
    endtask

    function automatic logic [23:0] ref_bcd(input int v, input int digits);
        logic [23:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_lz(input int v, input int digits);
        logic [5:0] m;
        int         p;
        m = '0;
        p = 10;
        for (int i = 1; i < digits; i++) begin
            m[i] = (v < p);
            p = p * 10;
        end
        return m;
    endfunction

    initial begin
        int          lat, ndone, d1, d2, cyc;
        logic        bz, dn, o;
        logic [23:0] b;
        logic [5:0]  l;
        int          sweep[$];

        tbl[0]  = '{0, 16'd0,     24'h000,   6'b000110, 1'b0, 9};
        tbl[1]  = '{0, 16'd255,   24'h255,   6'b000000, 1'b0, 9};
        tbl[2]  = '{0, 16'd7,     24'h007,   6'b000110, 1'b0, 9};
        tbl[3]  = '{0, 16'd42,    24'h042,   6'b000100, 1'b0, 9};
        tbl[4]  = '{0, 16'd100,   24'h100,   6'b000000, 1'b0, 9};
        tbl[5]  = '{0, 16'd10,    24'h010,   6'b000100, 1'b0, 9};
        tbl[6]  = '{0, 16'd199,   24'h199,   6'b000000, 1'b0, 9};
        tbl[7]  = '{1, 16'd99,    24'h99,    6'b000000, 1'b0, 9};
        tbl[8]  = '{1, 16'd100,   24'hFF,    6'b000000, 1'b1, 9};
        tbl[9]  = '{1, 16'd5,     24'h05,    6'b000010, 1'b0, 9};
        tbl[10] = '{1, 16'd255,   24'hFF,    6'b000000, 1'b1, 9};
        tbl[11] = '{1, 16'd0,     24'h00,    6'b000010, 1'b0, 9};
        tbl[12] = '{1, 16'd50,    24'h50,    6'b000000, 1'b0, 9};
        tbl[13] = '{2, 16'd65535, 24'h65535, 6'b000000, 1'b0, 17};
        tbl[14] = '{2, 16'd0,     24'h00000, 6'b011110, 1'b0, 17};
        tbl[15] = '{2, 16'd100,   24'h00100, 6'b011000, 1'b0, 17};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; bin16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy_a), 0);
        check("rst done", 32'(done_a), 0);
        check("rst bcd", 32'(bcd_a), 0);
        check("rst ovf", 32'(ovf_a), 0);
        check("rst lz", 32'(lz_a), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            convert(tbl[i].sel, tbl[i].bin, lat, b, l, o);
            check($sformatf("tbl%0d lat", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d bcd", i), 32'(b), 32'(tbl[i].bcd));
            check($sformatf("tbl%0d lz", i), 32'(l), 32'(tbl[i].lz));
            check($sformatf("tbl%0d ovf", i), 32'(o), 32'(tbl[i].ovf));
            @(posedge clk); #1;
        end

        // Second start during busy is ignored; binary changes after accept have no effect.
        bin16 = 16'd7; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bin16 = 16'd200; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 3; ndone = 0; d1 = -1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            cyc++;
            if (done_a) begin
                ndone++;
                if (d1 < 0) d1 = cyc;
            end
        end
        check("ign ndone", 32'(ndone), 1);
        check("ign lat", 32'(d1), 9);
        check("ign bcd", 32'(bcd_a), 32'h007);

        // Start held high: the done cycle accepts the next conversion.
        bin16 = 16'd7; start_a = 1'b1;
        @(posedge clk); #1;
        ndone = 0; d1 = -1; d2 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done_a) begin
                ndone++;
                if (d1 < 0) d1 = n;
                else if (d2 < 0) begin
                    d2 = n;
                    start_a = 1'b0;
                    check("hold bcd", 32'(bcd_a), 32'h007);
                    check("hold lz", 32'(lz_a), 32'b110);
                    check("hold busy", 32'(busy_a), 0);
                end
            end
        end
        start_a = 1'b0;
        check("hold first", 32'(d1), 9);
        check("hold gap", 32'(d2 - d1), 10);
        check("hold ndone", 32'(ndone), 2);

        // Reset mid-conversion aborts; reset beats a simultaneous start.
        bin16 = 16'd200; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy", 32'(busy_a), 0);
        check("abort done", 32'(done_a), 0);
        check("abort bcd", 32'(bcd_a), 0);
        check("abort ovf", 32'(ovf_a), 0);
        check("abort lz", 32'(lz_a), 0);
        start_a = 1'b1;
        @(posedge clk); #1;
        check("rst+start busy", 32'(busy_a), 0);
        rst = 1'b0; start_a = 1'b0;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done_a) ndone++;
        end
        check("abort ndone", 32'(ndone), 0);
        convert(0, 16'd42, lat, b, l, o);
        check("post bcd", 32'(b), 32'h042);
        check("post lz", 32'(l), 32'b100);
        check("post lat", 32'(lat), 9);

        // Outputs hold until the next done.
        convert(1, 16'd100, lat, b, l, o);
        bin16 = 16'd3;
        repeat (5) @(posedge clk);
        #1;
        rd(1, bz, dn, b, l, o);
        check("keep bcd", 32'(b), 32'hFF);
        check("keep ovf", 32'(o), 1);
        check("keep done", 32'(dn), 0);

        // Sampled sweep of the 16-bit, 5-digit configuration.
        for (int v = 0; v < 65536; v += 1021) sweep.push_back(v);
        sweep.push_back(9999);
        sweep.push_back(10000);
        sweep.push_back(59999);
        sweep.push_back(65535);
        foreach (sweep[i]) begin
            convert(2, 16'(sweep[i]), lat, b, l, o);
            check($sformatf("sw%0d lat", sweep[i]), 32'(lat), 17);
            check($sformatf("sw%0d bcd", sweep[i]), 32'(b), 32'(ref_bcd(sweep[i], 5)));
            check($sformatf("sw%0d lz", sweep[i]), 32'(l), 32'(ref_lz(sweep[i], 5)));
            check($sformatf("sw%0d ovf", sweep[i]), 32'(o), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
